// File: rtl/binary_codec_if.sv
// Decoder/encoder signal bundle for binary_codec.
// enc_multi exists only when BINARY_CODEC_MULTI_EN is defined.
interface binary_codec_if #(
  parameter int WIDTH = 5
);
  localparam int ADDR_WIDTH = $clog2(WIDTH);

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic                  dec_en;
  logic [WIDTH-1:0]      dec_out;
  logic [WIDTH-1:0]      enc_in;
  logic                  enc_valid;
  logic [ADDR_WIDTH-1:0] enc_addr;
`ifdef BINARY_CODEC_MULTI_EN
  logic                  enc_multi;

  modport master (
    output dec_addr,
    output dec_en,
    output enc_in,
    input  dec_out,
    input  enc_valid,
    input  enc_addr,
    input  enc_multi
  );

  modport slave (
    input  dec_addr,
    input  dec_en,
    input  enc_in,
    output dec_out,
    output enc_valid,
    output enc_addr,
    output enc_multi
  );
`else
  modport master (
    output dec_addr,
    output dec_en,
    output enc_in,
    input  dec_out,
    input  enc_valid,
    input  enc_addr
  );

  modport slave (
    input  dec_addr,
    input  dec_en,
    input  enc_in,
    output dec_out,
    output enc_valid,
    output enc_addr
  );
`endif
endinterface

// File: rtl/binary_codec.sv
// Registered binary decoder and lowest-index priority encoder.
// Optional multi-hot flag enabled by BINARY_CODEC_MULTI_EN.
module binary_codec #(
  parameter int WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  binary_codec_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(WIDTH);

  logic [WIDTH-1:0]      dec_out_d, dec_out_q;
  logic                  enc_valid_d, enc_valid_q;
  logic [ADDR_WIDTH-1:0] enc_addr_d, enc_addr_q;

  // Out-of-range addresses match no line, so they decode to zero.
  always_comb begin
    dec_out_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.dec_addr == ADDR_WIDTH'(i)) begin
        dec_out_d[i] = bus.dec_en;
      end
    end
  end

  // Scan high to low so the lowest set index is the last write.
  always_comb begin
    enc_valid_d = |bus.enc_in;
    enc_addr_d  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.enc_in[i]) begin
        enc_addr_d = ADDR_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_out_q   <= '0;
      enc_valid_q <= 1'b0;
      enc_addr_q  <= '0;
    end else begin
      dec_out_q   <= dec_out_d;
      enc_valid_q <= enc_valid_d;
      enc_addr_q  <= enc_addr_d;
    end
  end

  assign bus.dec_out   = dec_out_q;
  assign bus.enc_valid = enc_valid_q;
  assign bus.enc_addr  = enc_addr_q;

`ifdef BINARY_CODEC_MULTI_EN
  logic enc_multi_d, enc_multi_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    enc_multi_d =
      (bus.enc_in & (bus.enc_in - WIDTH'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_multi_q <= 1'b0;
    end else begin
      enc_multi_q <= enc_multi_d;
    end
  end

  assign bus.enc_multi = enc_multi_q;
`endif
endmodule

// File: tb/tb_binary_codec.sv
// Self-checking bench for binary_codec (WIDTH = 5).
// Directed plan steps followed by randomized traffic.
module tb_binary_codec;
  logic       clk = 1'b0;
  logic       rst;
  logic       loop;
  logic [4:0] enc_drv;
  int tests = 0;
  int fails = 0;
  logic done = 1'b0;

  binary_codec_if #(.WIDTH(5)) bus ();

  assign bus.enc_in = loop ? bus.dec_out : enc_drv;

  binary_codec #(.WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [4:0] m_dec;
  logic       m_val;
  logic [2:0] m_addr;
  logic       m_multi;
  logic       p_clean;
  logic       p_en;
  logic [2:0] p_a;

  function automatic logic [4:0] dec_ref(
    input logic en, input logic [2:0] a);
    if (en && a < 3'd5) return 5'b1 << a;
    return 5'b0;
  endfunction

  function automatic logic [2:0] low_ref(
    input logic [4:0] v);
    for (int i = 0; i < 5; i++)
      if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    fails++;
    $error("FAIL %s", tag);
  endtask

  task automatic step(
    input logic       r,
    input logic       en,
    input logic [2:0] a,
    input logic       lp,
    input logic [4:0] drv
  );
    logic [4:0] ein;
    logic       lv;
    logic [2:0] la;
    ein = lp ? m_dec : drv;
    rst = r;
    bus.dec_en = en;
    bus.dec_addr = a;
    loop = lp;
    enc_drv = drv;
    @(posedge clk);
    #1;
    if (r) begin
      m_dec = '0; m_val = 1'b0;
      m_addr = '0; m_multi = 1'b0;
    end else begin
      m_dec   = dec_ref(en, a);
      m_val   = |ein;
      m_addr  = low_ref(ein);
      m_multi = $countones(ein) >= 2;
    end
    chk("dec_out", 32'(bus.dec_out), 32'(m_dec));
    chk("enc_valid", 32'(bus.enc_valid), 32'(m_val));
    chk("enc_addr", 32'(bus.enc_addr), 32'(m_addr));
`ifdef BINARY_CODEC_MULTI_EN
    chk("enc_multi", 32'(bus.enc_multi), 32'(m_multi));
`endif
    if (!r && lp && p_clean) begin
      lv = p_en && (p_a < 3'd5);
      la = lv ? p_a : 3'd0;
      chk("loop_valid", 32'(bus.enc_valid), 32'(lv));
      chk("loop_addr", 32'(bus.enc_addr), 32'(la));
    end
    p_clean = !r;
    p_en = en;
    p_a = a;
  endtask

  initial begin
    #200000;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL timeout: bench did not finish");
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    loop = 1'b0;
    enc_drv = '0;
    bus.dec_en = 1'b0;
    bus.dec_addr = '0;
    m_dec = '0; m_val = 1'b0;
    m_addr = '0; m_multi = 1'b0;
    p_clean = 1'b0; p_en = 1'b0; p_a = '0;

    // Reset dominates active inputs.
    step(1'b1, 1'b1, 3'd3, 1'b0, 5'b01000);
    step(1'b1, 1'b1, 3'd3, 1'b0, 5'b01000);
    tests++;
    if (bus.dec_out !== 5'b0 ||
        bus.enc_valid !== 1'b0 ||
        bus.enc_addr !== 3'd0) begin
      fails++;
      $error("FAIL rst_state dec=%0h val=%0h addr=%0h",
             bus.dec_out, bus.enc_valid, bus.enc_addr);
    end
    tests++;
    if (bus.dec_out !== 5'b0) fail("rst_dec");
    tests++;
    if (bus.enc_addr !== 3'd0) fail("rst_addr");

    // Disabled sweep then flush.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 3'(i), 1'b1, 5'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 5'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 5'b0);

    // Enabled sweep, back to back.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'(i), 1'b1, 5'b0);
      tests++;
      if (bus.dec_out !== (5'b1 << i))
        fail("sweep_onehot");
    end
    // Out-of-range addresses.
    for (int i = 5; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i), 1'b1, 5'b0);
      tests++;
      if (bus.dec_out !== 5'b0) fail("oor_dec");
    end
    step(1'b0, 1'b0, 3'd0, 1'b1, 5'b0);

    // Multi-hot priority with direct enc_in.
    step(1'b0, 1'b0, 3'd0, 1'b0, 5'b10110);
    tests++;
    if (bus.enc_addr !== 3'd1) fail("multi_addr");
    tests++;
    if (bus.enc_valid !== 1'b1) fail("multi_val");
    step(1'b0, 1'b0, 3'd0, 1'b0, 5'b00100);
    tests++;
    if (bus.enc_addr !== 3'd2) fail("single_addr");

    // Mid-stream reset at address 2.
    step(1'b0, 1'b1, 3'd0, 1'b1, 5'b0);
    step(1'b0, 1'b1, 3'd1, 1'b1, 5'b0);
    step(1'b1, 1'b1, 3'd2, 1'b1, 5'b0);
    tests++;
    if (bus.dec_out !== 5'b0) fail("mid_rst_dec");
    tests++;
    if (bus.enc_valid !== 1'b0) fail("mid_rst_val");
    step(1'b0, 1'b1, 3'd3, 1'b1, 5'b0);
    tests++;
    if (bus.dec_out !== 5'b01000) fail("resume_dec");
    tests++;
    if (bus.enc_valid !== 1'b0) fail("resume_val");
    step(1'b0, 1'b1, 3'd4, 1'b1, 5'b0);
    tests++;
    if (bus.enc_addr !== 3'd3) fail("resume_addr");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 15) == 0),
           1'($urandom),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0),
           5'($urandom));
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
